// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-to-execute operand bus plus execute-to-writeback result bus
interface ex_stage_if;
  logic [3:0]  id_aluop;
  logic [31:0] id_reg1;
  logic [31:0] id_reg2;
  logic [4:0]  id_wreg;
  logic        id_wd;
  logic [4:0]  ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_wd;
  logic        ex_stall;
  modport master (
    output id_aluop, id_reg1, id_reg2, id_wreg, id_wd,
    input  ex_wreg, ex_wdata, ex_wd, ex_stall
  );
  modport slave (
    input  id_aluop, id_reg1, id_reg2, id_wreg, id_wd,
    output ex_wreg, ex_wdata, ex_wd, ex_stall
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: single-cycle ALU plus 32-step restoring unsigned divider; define EX_MUL_EN to add opcode 13 MUL
module ex_stage #(
  parameter bit DIV_ZERO_FAST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        isrem_q, isrem_d;
  logic [31:0] a, b, alu, res;
  logic        alu_ok, is_div, ok, wd, ge;
  logic [32:0] rs;
  assign a = bus.id_reg1;
  assign b = bus.id_reg2;
  assign is_div = (bus.id_aluop == 4'd11) || (bus.id_aluop == 4'd12);
  assign rs = {rem_q, quo_q[31]};
  assign ge = rs >= {1'b0, dvs_q};
  // combinational ALU; alu_ok marks opcodes that produce a single-cycle writeback
  always_comb begin
    alu = '0;
    alu_ok = 1'b1;
    case (bus.id_aluop)
      4'd1: alu = a + b;
      4'd2: alu = a - b;
      4'd3: alu = a & b;
      4'd4: alu = a | b;
      4'd5: alu = a ^ b;
      4'd6: alu = a << b[4:0];
      4'd7: alu = a >> b[4:0];
      4'd8: alu = $signed(a) >>> b[4:0];
      4'd9: alu = {31'd0, $signed(a) < $signed(b)};
      4'd10: alu = {31'd0, a < b};
`ifdef EX_MUL_EN
      4'd13: alu = a * b;
`endif
      default: alu_ok = 1'b0;
    endcase
  end
  // divider FSM: latch operands in IDLE, one restoring step per RUN cycle, present result in DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    isrem_d = isrem_q;
    case (state_q)
      IDLE: if (is_div) begin
        dvs_d = b;
        isrem_d = bus.id_aluop == 4'd12;
        cnt_d = '0;
        if (DIV_ZERO_FAST && b == '0) begin
          quo_d = '1;
          rem_d = a;
          state_d = DONE;
        end else begin
          quo_d = a;
          rem_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = ge ? rs[31:0] - dvs_q : rs[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and divider registers; reset abandons any divide in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      isrem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      isrem_q <= isrem_d;
    end
  end
  assign res = (state_q == DONE) ? (isrem_q ? rem_q : quo_q) : alu;
  assign ok = (state_q == DONE) || (state_q == IDLE && alu_ok);
  assign wd = rst & ok & bus.id_wd;
  assign bus.ex_wd = wd;
  assign bus.ex_wreg = wd ? bus.id_wreg : '0;
  assign bus.ex_wdata = wd ? res : '0;
  assign bus.ex_stall = rst & ((state_q == RUN) || (state_q == IDLE && is_div));
endmodule
